// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the load/run/unload sequencer.
package run_seq_pkg;

    // Sequencer phases.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    // Byte counts run 0..256, so they need nine bits.
    typedef logic [8:0] len_t;

    localparam int          DEF_START_CYCLES = 2;
    localparam logic [15:0] DEF_TIMEOUT      = 16'hFFFF;
    localparam len_t        MAX_LEN          = 9'd256;

    // Lengths beyond the 256-byte data memory cover the whole memory once.
    function automatic len_t clamp_len(input len_t len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating 16-bit counter that measures how long the processor runs.
module run_cycle_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        en_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;

    // Clear has priority; counting stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 16'd0;
        end else if (clear_i) begin
            count_q <= 16'd0;
        end else if (en_i && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Preloads a data memory, starts a processor, waits for it to halt (or
// times out), then streams a window of the data memory back out.
//
// Handshakes: a byte moves on in_* or out_* only on a rising edge where
// valid and ready are both high; out_valid, once raised, stays high with
// out_data stable until that edge, and valid never depends on ready.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int          START_CYCLES = DEF_START_CYCLES,
    parameter logic [15:0] TIMEOUT      = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [8:0]  load_len,
    input  logic [7:0]  unload_base,
    input  logic [8:0]  unload_len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_start,
    input  logic        cpu_done,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout,
    output logic [15:0] cycle_count,
    output logic [2:0]  dbg_state
);

    state_t      state_q;
    len_t        load_len_q;
    len_t        unload_len_q;
    logic [7:0]  unload_base_q;
    len_t        load_idx_q;
    len_t        unload_idx_q;
    logic [15:0] start_cnt_q;
    logic        cpu_start_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        timeout_q;

    logic        go_accept_d;
    logic        load_xfer_d;
    logic        unload_issue_d;
    logic        timeout_hit_d;
    logic [7:0]  unload_addr_d;
    logic [7:0]  mem_addr_d;
    logic [15:0] run_count;

    run_cycle_counter u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (go_accept_d),
        .en_i    (state_q == RUN),
        .count_o (run_count)
    );

    // Memory-port decode: writes track the input handshake in the same
    // cycle; a read is issued only when the output register is empty.
    always_comb begin
        go_accept_d    = (state_q == IDLE) && go;
        load_xfer_d    = (state_q == LOAD) && in_valid;
        unload_issue_d = (state_q == UNLOAD) && !out_valid_q &&
                         (unload_idx_q < unload_len_q);
        timeout_hit_d  = (state_q == RUN) && !cpu_done &&
                         (run_count == TIMEOUT - 16'd1);
        unload_addr_d  = unload_base_q + unload_idx_q[7:0];
        mem_addr_d     = 8'd0;
        if (load_xfer_d) begin
            mem_addr_d = load_idx_q[7:0];
        end else if (unload_issue_d) begin
            mem_addr_d = unload_addr_d;
        end
    end

    // Sequencer FSM with its registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            load_len_q    <= 9'd0;
            unload_len_q  <= 9'd0;
            unload_base_q <= 8'd0;
            load_idx_q    <= 9'd0;
            unload_idx_q  <= 9'd0;
            start_cnt_q   <= 16'd0;
            cpu_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'd0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        load_len_q    <= clamp_len(load_len);
                        unload_len_q  <= clamp_len(unload_len);
                        unload_base_q <= unload_base;
                        load_idx_q    <= 9'd0;
                        unload_idx_q  <= 9'd0;
                        start_cnt_q   <= 16'd0;
                        timeout_q     <= 1'b0;
                        if (clamp_len(load_len) == 9'd0) begin
                            state_q     <= START;
                            cpu_start_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        load_idx_q <= load_idx_q + 9'd1;
                        if (load_idx_q == load_len_q - 9'd1) begin
                            state_q     <= START;
                            cpu_start_q <= 1'b1;
                            start_cnt_q <= 16'd0;
                        end
                    end
                end
                START: begin
                    if (start_cnt_q == 16'(START_CYCLES - 1)) begin
                        cpu_start_q <= 1'b0;
                        state_q     <= RUN;
                    end else begin
                        start_cnt_q <= start_cnt_q + 16'd1;
                    end
                end
                RUN: begin
                    if (cpu_done) begin
                        state_q <= UNLOAD;
                    end else if (timeout_hit_d) begin
                        timeout_q <= 1'b1;
                        state_q   <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (unload_len_q == 9'd0) begin
                        state_q <= IDLE;
                    end else if (unload_issue_d) begin
                        out_data_q  <= mem_rdata;
                        out_valid_q <= 1'b1;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q  <= 1'b0;
                        unload_idx_q <= unload_idx_q + 9'd1;
                        if (unload_idx_q == unload_len_q - 9'd1) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == LOAD);
    assign mem_we      = load_xfer_d;
    assign mem_re      = unload_issue_d;
    assign mem_addr    = mem_addr_d;
    assign mem_wdata   = load_xfer_d ? in_data : 8'd0;
    assign cpu_start   = cpu_start_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q != IDLE);
    assign timeout     = timeout_q;
    assign cycle_count = run_count;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomised bench for run_sequencer: a byte-array memory model predicts
// every write and every returned byte; a negedge monitor checks them.
module tb_run_sequencer;

    localparam int          START_N = 2;
    localparam logic [15:0] TMO     = 16'd20;

    logic        clk;
    logic        reset_n;
    logic        go;
    logic [8:0]  load_len;
    logic [7:0]  unload_base;
    logic [8:0]  unload_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        cpu_start;
    logic        cpu_done;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [2:0]  dbg_state;

    logic [7:0]  tb_mem    [256];
    logic [7:0]  model_mem [256];
    logic [15:0] exp_wr_q  [$];
    logic [7:0]  exp_ra_q  [$];
    logic [7:0]  exp_q     [$];

    int n_cmp  = 0;
    int n_fail = 0;
    int out_pops = 0;
    bit rdy_rand = 0;

    run_sequencer #(.START_CYCLES(START_N), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .load_len(load_len),
        .unload_base(unload_base), .unload_len(unload_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .cpu_start(cpu_start),
        .cpu_done(cpu_done), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .timeout(timeout),
        .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    // Clock.
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = tb_mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: preload random contents, commit writes mid-cycle.
    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            tb_mem[i]    = v;
            model_mem[i] = v;
        end
        forever begin
            @(negedge clk);
            if (mem_we) tb_mem[mem_addr] = mem_wdata;
        end
    end

    // Output-ready driver.
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit         prev_hold;
        logic [7:0] prev_data;
        prev_hold = 0;
        prev_data = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mem_we && mem_re) check("we_re_overlap", {mem_we, mem_re}, 2'b10);
                if (mem_we) begin
                    if (exp_wr_q.size() == 0) check("wr_extra", mem_we, 0);
                    else check("mem_write", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
                end
                if (mem_re) begin
                    if (exp_ra_q.size() == 0) check("rd_extra", mem_re, 0);
                    else check("rd_addr", mem_addr, exp_ra_q.pop_front());
                end
                if (prev_hold) begin
                    check("out_valid_held", out_valid, 1);
                    check("out_stable", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("out_extra", out_valid, 0);
                    else check("out_data", out_data, exp_q.pop_front());
                    out_pops++;
                end
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
            end else begin
                prev_hold = 0;
            end
        end
    end

    // One full sequence. done_at: RUN cycle on which cpu_done is raised
    // (0 = never). noise: cpu_done during START and go during RUN.
    task automatic run_seq(input int ll, input int ub, input int ul, input int done_at,
                           input bit noise, input bit fixed, input bit abort);
        int lc, uc, hi, guard, exp_cycles, pops0;
        bit exp_to;
        logic [7:0] b;
        lc = (ll > 256) ? 256 : ll;
        uc = (ul > 256) ? 256 : ul;
        // in_valid while idle must not write.
        in_valid = 1; in_data = 8'($urandom);
        @(posedge clk); #1;
        in_valid = 0;
        go = 1; load_len = 9'(ll); unload_base = 8'(ub); unload_len = 9'(ul);
        @(posedge clk); #1;
        go = 0; load_len = 9'($urandom); unload_base = 8'($urandom); unload_len = 9'($urandom);
        for (int i = 0; i < lc; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 0; in_data = 8'($urandom);
                @(posedge clk); #1;
            end
            b = fixed ? (8'hA1 + 8'(i * 17)) : 8'($urandom);
            in_valid = 1; in_data = b;
            exp_wr_q.push_back({8'(i), b});
            model_mem[i] = b;
            @(posedge clk); #1;
        end
        in_valid = 0;
        for (int j = 0; j < uc; j++) begin
            exp_q.push_back(model_mem[(ub + j) % 256]);
            exp_ra_q.push_back(8'((ub + j) % 256));
        end
        // START: count cpu_start high cycles.
        hi = 0; guard = 0;
        while (guard < 100) begin
            if (cpu_start) begin
                hi++;
                if (noise) cpu_done = 1;
            end else if (hi > 0) begin
                break;
            end
            @(posedge clk); #1;
            guard++;
        end
        cpu_done = 0;
        check("start_cycles", hi, START_N);
        // RUN.
        exp_cycles = (done_at >= 1 && done_at <= int'(TMO)) ? done_at : int'(TMO);
        exp_to     = !(done_at >= 1 && done_at <= int'(TMO));
        for (int k = 1; k <= exp_cycles; k++) begin
            cpu_done = (k == done_at);
            in_valid = 1'($urandom_range(0, 1));
            if (noise && k == 2) begin
                go = 1; load_len = 9'($urandom); unload_len = 9'($urandom);
                unload_base = 8'($urandom);
            end
            if (k == 1) check("in_ready_run", in_ready, 0);
            @(posedge clk); #1;
            go = 0; cpu_done = 0;
        end
        in_valid = 0;
        check("cycle_count", cycle_count, exp_cycles);
        check("timeout_flag", timeout, exp_to);
        pops0 = out_pops;
        if (abort) begin
            guard = 0;
            while (!(out_pops == pops0 + 1 && out_valid) && guard < 500) begin
                @(posedge clk); #1;
                guard++;
            end
            check("abort_reached_byte2", out_pops - pops0, 1);
            #2 reset_n = 0;
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_mem_re", mem_re, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_out_data", out_data, 0);
            check("rst_cycle_count", cycle_count, 0);
            exp_q.delete();
            exp_ra_q.delete();
            @(posedge clk); #1;
            reset_n = 1;
            repeat (5) @(posedge clk);
            #1;
            check("post_rst_idle", busy, 0);
            return;
        end
        if (uc == 0) begin
            @(posedge clk); #1;
            check("unload0_one_cycle", busy, 0);
        end
        guard = 0;
        while (busy && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("seq_end", busy, 0);
        check("cycle_count_held", cycle_count, exp_cycles);
        check("out_bytes_left", exp_q.size(), 0);
        check("wr_left", exp_wr_q.size(), 0);
        check("out_byte_count", out_pops - pops0, uc);
    endtask

    // Stimulus.
    initial begin
        reset_n = 0; go = 0; load_len = 0; unload_base = 0; unload_len = 0;
        in_valid = 0; in_data = 0; cpu_done = 0;
        #23;
        check("reset_busy", busy, 0);
        check("reset_cpu_start", cpu_start, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_mem_port", {mem_we, mem_re, mem_addr, mem_wdata}, 0);
        check("reset_timeout", timeout, 0);
        check("reset_cycle_count", cycle_count, 0);
        check("reset_out_data", out_data, 0);
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;

        rdy_rand = 0;
        run_seq(3, 8'h00, 3, 5, 1'b0, 1'b1, 1'b0);   // A1,B2,C3 written and read back
        run_seq(0, 8'h10, 2, 10, 1'b1, 1'b0, 1'b0);  // no load, done after 10
        run_seq(2, 8'h40, 5, 0, 1'b0, 1'b0, 1'b0);   // timeout at 20
        run_seq(2, 8'h40, 2, 20, 1'b0, 1'b0, 1'b0);  // done on timeout cycle
        run_seq(1, 8'h00, 3, 1, 1'b0, 1'b0, 1'b0);   // done on first RUN cycle
        run_seq(4, 8'h00, 0, 3, 1'b0, 1'b0, 1'b0);   // empty unload
        rdy_rand = 1;
        run_seq(4, 8'hFE, 4, 7, 1'b1, 1'b0, 1'b0);   // address wrap, ready toggling
        run_seq(256, 8'h00, 256, 4, 1'b0, 1'b0, 1'b0);
        run_seq(300, 8'h80, 511, 6, 1'b1, 1'b0, 1'b0); // clamped lengths
        run_seq(2, 8'h20, 4, 5, 1'b0, 1'b0, 1'b1);   // reset during byte 2
        run_seq(3, 8'h00, 3, 2, 1'b0, 1'b0, 1'b0);   // clean after abort
        for (int n = 0; n < 10; n++) begin
            run_seq($urandom_range(0, 40), $urandom_range(0, 255), $urandom_range(0, 40),
                    $urandom_range(0, 25), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
